// File: rtl/dmem_arbiter_if.sv
// Purpose: requester-side bundle for dmem_arbiter; index p of each vector belongs to port p (0 = core, 1 = aux).
// Latency: none here; the arbiter answers an accepted request with a one-cycle resp_valid pulse two cycles later.
// Backpressure: requester holds valid/we/addr/wdata until req_ready; responses cannot be stalled.
// Signals: req_valid/req_ready/req_we [1:0], req_addr/req_wdata [1:0][31:0],
//          resp_valid [1:0], resp_rdata [31:0] (shared), resp_err (shared).
interface dmem_arbiter_if;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_we;
    logic [1:0][31:0]  req_addr;
    logic [1:0][31:0]  req_wdata;
    logic [1:0]        resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Purpose: two-port round-robin sequencer in front of a single registered-read dmem, with error-tagged responses.
// Latency: IDLE (accept) -> ACCESS (dmem cycle) -> RESP (response pulse); one transaction per 3 cycles, no overlap.
// Backpressure: req_ready only in IDLE for the winning port; ACCESS and RESP refuse all requests.
// Ports: clk, rst (sync, active-high); req_if (slave modport of dmem_arbiter_if);
//        mem_write_en/mem_addr/mem_write_data to dmem, mem_read_data from dmem (valid one cycle after addr).
module dmem_arbiter #(
    parameter int MEM_BYTES = 32
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave req_if,
    output logic          mem_write_en,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_write_data,
    input  logic [31:0]   mem_read_data
);

    localparam logic [31:0] LAST_WORD_ADDR = 32'(MEM_BYTES - 4);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic         last_grant_q, last_grant_d;
    logic         port_q, port_d;
    logic         we_q, we_d;
    logic         err_q, err_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  wdata_q, wdata_d;

    logic         any_vld;
    logic         winner;
    logic [31:0]  sel_addr;
    logic [1:0]   req_ready_c;
    logic [1:0]   resp_valid_c;
    logic         resp_err_c;
    logic [31:0]  resp_rdata_c;

    always_comb begin
        any_vld = |req_if.req_valid;
        // Contested cycle goes to the port that did not win last time;
        // otherwise the single requester wins (valid[1] selects port 1).
        if (&req_if.req_valid) begin
            winner = ~last_grant_q;
        end else begin
            winner = req_if.req_valid[1];
        end
        sel_addr = req_if.req_addr[winner];

        state_d      = state_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        we_d         = we_q;
        err_d        = err_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;

        req_ready_c    = 2'b00;
        resp_valid_c   = 2'b00;
        resp_err_c     = 1'b0;
        resp_rdata_c   = 32'h0;
        mem_write_en   = 1'b0;
        mem_addr       = 32'h0;
        mem_write_data = 32'h0;

        case (state_q)
            ST_IDLE: begin
                // A request seen while rst is high is never accepted.
                if (any_vld && !rst) begin
                    req_ready_c[winner] = 1'b1;
                    port_d       = winner;
                    last_grant_d = winner;
                    we_d         = req_if.req_we[winner];
                    addr_d       = sel_addr;
                    wdata_d      = req_if.req_wdata[winner];
                    // Full 32-bit unsigned compare: top-of-space addresses are errors, no wrap.
                    err_d        = (sel_addr[1:0] != 2'b00) || (sel_addr > LAST_WORD_ADDR);
                    state_d      = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_addr       = addr_q;
                mem_write_data = wdata_q;
                // dmem samples on the closing edge; rst gating keeps a reset
                // landing mid-access from committing the write.
                mem_write_en   = we_q & ~err_q & ~rst;
                state_d        = ST_RESP;
            end
            ST_RESP: begin
                if (!rst) begin
                    resp_valid_c[port_q] = 1'b1;
                    resp_err_c           = err_q;
                    resp_rdata_c         = err_q ? 32'hFFFF_FFFF : mem_read_data;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req_if.req_ready  = req_ready_c;
    assign req_if.resp_valid = resp_valid_c;
    assign req_if.resp_err   = resp_err_c;
    assign req_if.resp_rdata = resp_rdata_c;

    // Reset drops any in-flight transaction; last_grant=1 hands the first contest to port 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            port_q       <= 1'b0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            we_q         <= we_d;
            err_q        <= err_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

endmodule
